// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller: funct3 encodings,
// FSM state type and the legality check for load/store size and alignment.
package mem_pkg;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone,
        StFault
    } state_t;

    // Stores reuse the load encodings; only the size bits matter for them.
    function automatic logic is_illegal(input logic [2:0] func, input logic [1:0] off);
        logic ill;
        case (func)
            F_B, F_BU: ill = 1'b0;
            F_H, F_HU: ill = off[0];
            F_W:       ill = (off != 2'b00);
            default:   ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a bus read word and sign- or
// zero-extends it to 32 bits according to funct3.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  func,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        unique case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (func)
            F_B:     data = {{24{byte_sel[7]}}, byte_sel};
            F_BU:    data = {24'h000000, byte_sel};
            F_H:     data = {{16{half_sel[15]}}, half_sel};
            F_HU:    data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the EX/MEM load/store over a req/ack data bus, stalling the pipeline
// while the access is in flight and reporting misalignment, bus errors and timeouts.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned TIMEOUT_W = $clog2(TIMEOUT) + 1
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        Wmem,
    input  logic        Rmem,
    input  logic [2:0]  func,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [2:0]           func_q, func_d;
    logic [1:0]           off_q, off_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          ld_q, ld_d;

    logic        acc;
    logic        illegal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] aligned;

    // Gating with reset keeps stall low while reset is held even if the
    // pipeline still presents the abandoned request.
    assign acc     = (Wmem | Rmem) & nReset;
    assign illegal = is_illegal(func, addr[1:0]);

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata;
        case (func[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    mem_load_align u_align (
        .rdata  (bus_rdata),
        .func   (func_q),
        .offset (off_q),
        .data   (aligned)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        func_d       = func_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        ld_d         = ld_q;
        stall        = 1'b0;
        misalign     = 1'b0;
        load_valid   = 1'b0;
        access_fault = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    if (illegal) begin
                        misalign = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        we_d    = Wmem;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        func_d  = func;
                        off_d   = addr[1:0];
                        cnt_d   = '0;
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                stall = 1'b1;
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (bus_err) begin
                    state_d = StFault;
                end else if (bus_ack) begin
                    if (!we_q) ld_d = aligned;
                    state_d = StDone;
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
                    state_d = StFault;
                end
            end
            StDone: begin
                load_valid = ~we_q;
                state_d    = StIdle;
            end
            StFault: begin
                access_fault = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            func_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            func_q  <= func_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
        end
    end

    assign bus_req   = (state_q == StBus);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign load_data = ld_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, misalignment, faults and
// mid-access reset, each against hand-computed expected values.
module tb_mem_access_ctrl;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        Wmem = 1'b0;
    logic        Rmem = 1'b0;
    logic [2:0]  func = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Values seen on the bus during the most recent access.
    logic        seen_req;
    logic        seen_we;
    logic [31:0] seen_addr;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;
    logic        bus_stable;

    int          stall_cyc;
    logic        saw_lv;
    logic        saw_af;
    logic [31:0] ld;

    mem_access_ctrl dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .addr         (addr),
        .wdata        (wdata),
        .Wmem         (Wmem),
        .Rmem         (Rmem),
        .func         (func),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign     (misalign),
        .access_fault (access_fault),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called with the request already on the inputs, just after a rising edge.
    // Ends one cycle after the DONE/FAULT cycle with the request withdrawn.
    task automatic do_access(input int waits, input logic err, input logic give_ack);
        int bus_cyc;
        bus_cyc    = 0;
        stall_cyc  = 0;
        seen_req   = 1'b0;
        bus_stable = 1'b1;
        #1;
        for (int guard = 0; guard < 40; guard++) begin
            if (!stall) break;
            stall_cyc++;
            if (bus_req) begin
                if (!seen_req) begin
                    seen_req   = 1'b1;
                    seen_we    = bus_we;
                    seen_addr  = bus_addr;
                    seen_be    = bus_be;
                    seen_wdata = bus_wdata;
                end else if (bus_we !== seen_we || bus_addr !== seen_addr ||
                             bus_be !== seen_be || bus_wdata !== seen_wdata) begin
                    bus_stable = 1'b0;
                end
                if (bus_cyc == waits) begin
                    bus_ack = give_ack;
                    bus_err = err;
                end
                bus_cyc++;
            end
            @(posedge Clock);
            #1;
            bus_ack = 1'b0;
            bus_err = 1'b0;
        end
        check_eq("stall_released", {31'd0, stall}, 32'd0);
        saw_lv = load_valid;
        saw_af = access_fault;
        ld     = load_data;
        Wmem   = 1'b0;
        Rmem   = 1'b0;
        @(posedge Clock);
        #1;
        check_eq("lv_one_cycle", {31'd0, load_valid}, 32'd0);
        check_eq("af_one_cycle", {31'd0, access_fault}, 32'd0);
        check_eq("idle_no_req", {31'd0, bus_req}, 32'd0);
    endtask

    task automatic issue(input logic w, input logic r, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        Wmem  = w;
        Rmem  = r;
        func  = f;
        addr  = a;
        wdata = d;
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_outputs", {26'd0, stall, load_valid, misalign, access_fault,
                                 bus_req, bus_we}, 32'd0);
        check_eq("rst_be", {28'd0, bus_be}, 32'd0);
        check_eq("rst_load_data", load_data, 32'd0);
        @(negedge Clock);
        nReset = 1'b1;
        @(posedge Clock);
        #1;

        // 1: SW with two wait cycles
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        do_access(2, 1'b0, 1'b1);
        check_eq("sw_stall_cycles", stall_cyc, 32'd4);
        check_eq("sw_be", {28'd0, seen_be}, 32'h0000_000F);
        check_eq("sw_addr", seen_addr, 32'h0000_0100);
        check_eq("sw_we", {31'd0, seen_we}, 32'd1);
        check_eq("sw_wdata", seen_wdata, 32'hDEAD_BEEF);
        check_eq("sw_stable", {31'd0, bus_stable}, 32'd1);
        check_eq("sw_no_lv", {31'd0, saw_lv}, 32'd0);

        // 2: SB to the top byte lane
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5);
        do_access(0, 1'b0, 1'b1);
        check_eq("sb_stall_cycles", stall_cyc, 32'd2);
        check_eq("sb_be", {28'd0, seen_be}, 32'h0000_0008);
        check_eq("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
        check_eq("sb_addr", seen_addr, 32'h0000_0100);

        // 3: loads with sign/zero extension
        bus_rdata = 32'h0080_0000;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h0);
        do_access(1, 1'b0, 1'b1);
        check_eq("lb_data", ld, 32'hFFFF_FF80);
        check_eq("lb_valid", {31'd0, saw_lv}, 32'd1);
        check_eq("lb_be", {28'd0, seen_be}, 32'h0000_0004);
        check_eq("lb_we", {31'd0, seen_we}, 32'd0);

        issue(1'b0, 1'b1, 3'b100, 32'h0000_0102, 32'h0);
        do_access(0, 1'b0, 1'b1);
        check_eq("lbu_data", ld, 32'h0000_0080);
        check_eq("lbu_valid", {31'd0, saw_lv}, 32'd1);

        bus_rdata = 32'h8001_0000;
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0);
        do_access(0, 1'b0, 1'b1);
        check_eq("lh_data", ld, 32'hFFFF_8001);
        check_eq("lh_be", {28'd0, seen_be}, 32'h0000_000C);

        issue(1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'h0);
        do_access(0, 1'b0, 1'b1);
        check_eq("lhu_data", ld, 32'h0000_8001);

        bus_rdata = 32'h1234_5678;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h0);
        do_access(3, 1'b0, 1'b1);
        check_eq("lw_data", ld, 32'h1234_5678);
        check_eq("lw_stall_cycles", stall_cyc, 32'd5);

        // load_data survives a store
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0000_BEEF);
        do_access(0, 1'b0, 1'b1);
        check_eq("sh_be", {28'd0, seen_be}, 32'h0000_000C);
        check_eq("sh_wdata", seen_wdata, 32'hBEEF_BEEF);
        check_eq("ld_hold", load_data, 32'h1234_5678);

        // 4: misaligned LW and unsupported funct3
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h0);
        #1;
        check_eq("mis_lw_flag", {31'd0, misalign}, 32'd1);
        check_eq("mis_lw_stall", {31'd0, stall}, 32'd0);
        @(posedge Clock);
        #1;
        check_eq("mis_lw_no_req", {31'd0, bus_req}, 32'd0);
        issue(1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0);
        #1;
        check_eq("mis_f011_flag", {31'd0, misalign}, 32'd1);
        check_eq("mis_f011_stall", {31'd0, stall}, 32'd0);
        @(posedge Clock);
        #1;
        check_eq("mis_f011_no_req", {31'd0, bus_req}, 32'd0);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0);
        #1;
        check_eq("mis_sh_flag", {31'd0, misalign}, 32'd1);
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check_eq("mis_drop", {31'd0, misalign}, 32'd0);
        @(posedge Clock);
        #1;
        check_eq("mis_never_req", {31'd0, bus_req}, 32'd0);

        // 5: timeout and err+ack
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0);
        do_access(0, 1'b0, 1'b0);
        check_eq("to_stall_cycles", stall_cyc, 32'd17);
        check_eq("to_fault", {31'd0, saw_af}, 32'd1);
        check_eq("to_no_lv", {31'd0, saw_lv}, 32'd0);

        bus_rdata = 32'hCAFE_F00D;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h0);
        do_access(1, 1'b1, 1'b1);
        check_eq("err_fault", {31'd0, saw_af}, 32'd1);
        check_eq("err_no_lv", {31'd0, saw_lv}, 32'd0);
        check_eq("err_ld_hold", ld, 32'h1234_5678);

        // 6: reset in the middle of a bus access
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check_eq("pre_rst_req", {31'd0, bus_req}, 32'd1);
        nReset = 1'b0;
        #1;
        check_eq("rst_mid_req", {31'd0, bus_req}, 32'd0);
        check_eq("rst_mid_stall", {31'd0, stall}, 32'd0);
        @(negedge Clock);
        nReset = 1'b1;
        do_access(2, 1'b0, 1'b1);
        check_eq("post_rst_stall_cycles", stall_cyc, 32'd4);
        check_eq("post_rst_be", {28'd0, seen_be}, 32'h0000_000F);
        check_eq("post_rst_addr", seen_addr, 32'h0000_0100);
        check_eq("post_rst_we", {31'd0, seen_we}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
